// File: rtl/render_scheduler.sv
// ---------------------------------------------------------------------------
// render_scheduler
//
// Per-frame sequencer in the clk_33m domain. It sits between the VGA frame
// timing, the painter and the runner game logic. Every frame it restarts the
// painter, waits for the paint pass to finish, then issues exactly one game
// logic tick. Because of this ordering the sprite/position list only changes
// between paint passes. Paint overruns are queued one deep, and a watchdog
// ends a hung paint pass.
//
// Optional feature macro: RENDER_SCHED_STATS_EN
//   When defined, an extra output overrun_cnt counts frame_start pulses that
//   arrive while a frame is in flight or already queued. The count saturates.
//
// Parameters
//   CLEAR_CYCLES    cycles painter_rst is held high per frame (>=1)
//   TIMEOUT_CYCLES  max PAINT cycles before the pass is abandoned (>=2)
//   CNT_W           width of the frame / overrun counters
//
// Ports
//   clk_33m           in   sole clock, all logic on posedge
//   reset_n           in   asynchronous active-low reset
//   enable            in   1 = run frames, 0 = stop at next frame boundary
//   frame_start       in   1-cycle pulse, synchronous to clk_33m
//   painter_finished  in   level from painter, 1 = current pass done
//   painter_rst       out  painter restart, active high
//   logic_tick        out  1-cycle pulse, advance game logic one step
//   busy              out  1 while in CLEAR / PAINT / TICK
//   frame_cnt         out  frames completed, wraps
//   overrun_cnt       out  (RENDER_SCHED_STATS_EN only) saturating overrun count
//   timeout_flag      out  sticky, a PAINT pass hit the watchdog
// ---------------------------------------------------------------------------
module render_scheduler #(
  parameter int CLEAR_CYCLES   = 4,
  parameter int TIMEOUT_CYCLES = 500000,
  parameter int CNT_W          = 16
) (
  input  logic             clk_33m,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             frame_start,
  input  logic             painter_finished,
  output logic             painter_rst,
  output logic             logic_tick,
  output logic             busy,
  output logic [CNT_W-1:0] frame_cnt,
`ifdef RENDER_SCHED_STATS_EN
  output logic [CNT_W-1:0] overrun_cnt,
`endif
  output logic             timeout_flag
);

  // Counter widths only need to reach LAST (= count - 1).
  localparam int CLR_W = (CLEAR_CYCLES > 1) ? $clog2(CLEAR_CYCLES) : 1;
  localparam int WD_W  = $clog2(TIMEOUT_CYCLES);

  localparam logic [CLR_W-1:0] CLR_LAST = CLR_W'(CLEAR_CYCLES - 1);
  localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    PAINT = 2'd2,
    TICK  = 2'd3
  } state_t;

  state_t           state;
  state_t           next_state;
  logic             pending;
  logic [CLR_W-1:0] clear_cnt;
  logic [WD_W-1:0]  wd_cnt;

  logic             painter_rst_d;
  logic             logic_tick_d;
  logic             busy_d;
  logic             pending_d;
  logic             restart;
  logic             paint_done;
  logic             timeout_hit;

  // Next-state and next-output decode. All outputs are registered from the
  // next state, so each output changes in the same cycle as the state it
  // belongs to.
  always_comb begin
    next_state  = state;
    paint_done  = 1'b0;
    timeout_hit = 1'b0;

    // While wd_cnt is 0 we are in the first PAINT cycle. A finished level
    // seen there can still be stale from the previous pass, so it is ignored.
    if (state == PAINT) begin
      paint_done  = (wd_cnt != '0) && painter_finished;
      timeout_hit = (wd_cnt == WD_LAST) && !paint_done;
    end

    case (state)
      IDLE: begin
        if (enable && (frame_start || pending)) begin
          next_state = CLEAR;
        end
      end
      CLEAR: begin
        if (clear_cnt == CLR_LAST) begin
          next_state = PAINT;
        end
      end
      PAINT: begin
        if (paint_done || timeout_hit) begin
          next_state = TICK;
        end
      end
      TICK: begin
        // A queued frame (or one arriving right now) starts without first
        // passing through IDLE, so a backlog costs no extra cycle.
        if (enable && (pending || frame_start)) begin
          next_state = CLEAR;
        end else begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase

    restart = (next_state == CLEAR) && ((state == IDLE) || (state == TICK));

    // The pending slot is one deep: consuming it wins over a new pulse.
    // Pulses while it is already set are simply absorbed.
    pending_d = pending;
    if (restart) begin
      pending_d = 1'b0;
    end else if (frame_start && (state != IDLE)) begin
      pending_d = 1'b1;
    end

    painter_rst_d = (next_state == IDLE) || (next_state == CLEAR);
    logic_tick_d  = (next_state == TICK);
    busy_d        = (next_state != IDLE);
  end

  // State register plus the registered outputs and sticky flags.
  always_ff @(posedge clk_33m or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      pending      <= 1'b0;
      painter_rst  <= 1'b1;
      logic_tick   <= 1'b0;
      busy         <= 1'b0;
      frame_cnt    <= '0;
      timeout_flag <= 1'b0;
    end else begin
      state       <= next_state;
      pending     <= pending_d;
      painter_rst <= painter_rst_d;
      logic_tick  <= logic_tick_d;
      busy        <= busy_d;
      if (logic_tick_d) begin
        frame_cnt <= frame_cnt + 1'b1;
      end
      if (timeout_hit) begin
        timeout_flag <= 1'b1;
      end
    end
  end

  // CLEAR length counter and PAINT watchdog. Each one restarts from 0
  // whenever its state is entered.
  always_ff @(posedge clk_33m or negedge reset_n) begin
    if (!reset_n) begin
      clear_cnt <= '0;
      wd_cnt    <= '0;
    end else begin
      if ((state == CLEAR) && (next_state == CLEAR)) begin
        clear_cnt <= clear_cnt + 1'b1;
      end else begin
        clear_cnt <= '0;
      end
      if ((state == PAINT) && (next_state == PAINT)) begin
        wd_cnt <= wd_cnt + 1'b1;
      end else begin
        wd_cnt <= '0;
      end
    end
  end

`ifdef RENDER_SCHED_STATS_EN
  // An overrun is a frame_start that cannot be serviced right away. This is
  // the case when a frame is in flight or one is already queued.
  always_ff @(posedge clk_33m or negedge reset_n) begin
    if (!reset_n) begin
      overrun_cnt <= '0;
    end else if (frame_start && (busy || pending) && (overrun_cnt != '1)) begin
      overrun_cnt <= overrun_cnt + 1'b1;
    end
  end
`else
  // Statistics build option not selected: no overrun counter.
`endif

endmodule
